// File: rtl/addsub9_acc.sv
// Add/subtract accumulator: sums COUNT signed 9-bit operands, then presents the result until consumed.
// Optional macro ADDSUB9_ACC_SAT_EN clamps overflowing beats to 0x0FF / 0x100 instead of wrapping.
module addsub9_acc #(
  parameter int COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_data,
  input  logic       in_sub,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic       out_carry,
  output logic       out_ovf,
  output logic [1:0] fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and the payload is held while valid is high and ready low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t     state;
  logic [8:0] acc;
  logic [7:0] cnt;
  logic       carry;
  logic       ovf;

  logic [8:0] operand;
  logic [9:0] sum;
  logic       beat_ovf;
  logic [8:0] beat_acc;
  logic       take;

  // Subtraction is acc + ~data + 1; the carry-in reuses in_sub.
  always_comb begin
    operand  = in_sub ? ~in_data : in_data;
    sum      = {1'b0, acc} + {1'b0, operand} + {9'd0, in_sub};
    beat_ovf = (acc[8] == operand[8]) && (sum[8] != acc[8]);
`ifdef ADDSUB9_ACC_SAT_EN
    if (beat_ovf) beat_acc = acc[8] ? 9'h100 : 9'h0FF;
    else          beat_acc = sum[8:0];
`else
    beat_acc = sum[8:0];
`endif
    take = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 9'd0;
      cnt       <= 8'd0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (flush) begin
            state <= IDLE;
            acc   <= 9'd0;
            cnt   <= 8'd0;
            carry <= 1'b0;
            ovf   <= 1'b0;
          end else if (take) begin
            acc   <= beat_acc;
            carry <= sum[9];
            ovf   <= ovf | beat_ovf;
            cnt   <= cnt + 8'd1;
            if (cnt == LAST) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        OUT: begin
          // flush is deliberately ignored here; only the consumer releases the result.
          if (out_ready) begin
            state     <= IDLE;
            acc       <= 9'd0;
            cnt       <= 8'd0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= 9'd0;
          cnt       <= 8'd0;
          carry     <= 1'b0;
          ovf       <= 1'b0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_valid ? acc : 9'd0;
  assign out_carry = out_valid & carry;
  assign out_ovf   = out_valid & ovf;
  assign fsm_state = state;

endmodule

// File: tb/tb_addsub9_acc.sv
// Bench for addsub9_acc: directed scenarios plus random traffic, checked every cycle
// against a signed-arithmetic reference model.
module tb_addsub9_acc;

  localparam int COUNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = 9'd0;
  logic       in_sub = 1'b0;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic       out_carry;
  logic       out_ovf;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [8:0] m_acc   = 9'd0;
  int         m_cnt   = 0;
  logic       m_carry = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_full  = 1'b0;

  addsub9_acc #(.COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_ovf(out_ovf), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = 9'd0; m_cnt = 0; m_carry = 1'b0; m_ovf = 1'b0; m_full = 1'b0;
  endtask

  task automatic model_beat(input logic [8:0] d, input logic sub);
    int a, b, t;
    a = int'($signed(m_acc));
    b = int'($signed(d));
    t = sub ? a - b : a + b;
    m_carry = sub ? (m_acc >= d) : ((int'(m_acc) + int'(d)) >= 512);
    if (t > 255 || t < -256) m_ovf = 1'b1;
`ifdef ADDSUB9_ACC_SAT_EN
    if (t > 255)       m_acc = 9'h0FF;
    else if (t < -256) m_acc = 9'h100;
    else               m_acc = 9'(t);
`else
    m_acc = 9'(t);
`endif
  endtask

  // One clock: advance the model on the inputs currently driven, then compare all outputs.
  task automatic tick();
    if (rst) model_clear();
    else if (m_full) begin
      if (out_ready) model_clear();
    end else if (flush) model_clear();
    else if (in_valid) begin
      model_beat(in_data, in_sub);
      m_cnt++;
      if (m_cnt == COUNT) m_full = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("in_ready",  9'(in_ready),  9'(!m_full));
    check("out_valid", 9'(out_valid), 9'(m_full));
    check("out_data",  out_data,      m_full ? m_acc : 9'd0);
    check("out_carry", 9'(out_carry), 9'(m_full & m_carry));
    check("out_ovf",   9'(out_ovf),   9'(m_full & m_ovf));
  endtask

  task automatic beat(input logic [8:0] d, input logic sub);
    in_valid = 1'b1; in_data = d; in_sub = sub;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_idle", 9'(out_valid), 9'd0);
  endtask

  initial begin
    logic [8:0] pick;
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 9'(in_ready), 9'd1);
    check("rst_valid", 9'(out_valid), 9'd0);

    // 10+20+30+40, latency and hold with in_valid high
    beat(9'd10, 1'b0); beat(9'd20, 1'b0); beat(9'd30, 1'b0);
    check("r031_early", 9'(out_valid), 9'd0);
    beat(9'd40, 1'b0);
    check("r031_valid", 9'(out_valid), 9'd1);
    check("r031_data",  out_data, 9'h064);
    check("r031_carry", 9'(out_carry), 9'd0);
    check("r031_ovf",   9'(out_ovf), 9'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 9'($urandom); in_sub = 1'($urandom);
      tick();
      check("r034_data",  out_data, 9'h064);
      check("r034_ready", 9'(in_ready), 9'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("r034_idle_ready", 9'(in_ready), 9'd1);
    check("r034_idle_valid", 9'(out_valid), 9'd0);

    // add 100, sub 5, add 1, sub 1; flush ignored while holding
    beat(9'd100, 1'b0); beat(9'd5, 1'b1); beat(9'd1, 1'b0); beat(9'd1, 1'b1);
    check("r032_data",  out_data, 9'h05F);
    check("r032_carry", 9'(out_carry), 9'd1);
    check("r032_ovf",   9'(out_ovf), 9'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("out_flush_ignored", 9'(out_valid), 9'd1);
    drain();

    // positive overflow
    beat(9'd200, 1'b0); beat(9'd100, 1'b0); beat(9'd0, 1'b0); beat(9'd0, 1'b0);
    check("r033_ovf", 9'(out_ovf), 9'd1);
`ifdef ADDSUB9_ACC_SAT_EN
    check("r033_data", out_data, 9'h0FF);
`else
    check("r033_data", out_data, 9'h12C);
`endif
    drain();

    // flush beats a simultaneous operand
    beat(9'd7, 1'b0); beat(9'd7, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_data = 9'd9; in_sub = 1'b0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    beat(9'd1, 1'b0); beat(9'd2, 1'b0); beat(9'd3, 1'b0); beat(9'd4, 1'b0);
    check("r035_data", out_data, 9'h00A);
    drain();

    // reset while holding a result
    for (int i = 0; i < 4; i++) beat(9'd1, 1'b0);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("r036_valid", 9'(out_valid), 9'd0);
    check("r036_ready", 9'(in_ready), 9'd1);
    for (int i = 0; i < 4; i++) beat(9'd1, 1'b0);
    check("r036_data", out_data, 9'h004);
    drain();

    // random traffic with corner operands
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: pick = 9'h0FF;
        1: pick = 9'h100;
        2: pick = 9'h1FF;
        3: pick = 9'h000;
        default: pick = 9'($urandom);
      endcase
      rst       = ($urandom_range(0, 79) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = 1'($urandom);
      in_data   = pick;
      in_sub    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub9_acc.md
ADDSUB9_ACC -- requirements
Module: addsub9_acc

Interface
REQ-001 SHALL have parameter COUNT, default 4, number of operands accumulated per result (legal 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand beat present.
REQ-005 SHALL have port in_ready  output  1  block accepts operand.
REQ-006 SHALL have port in_data  input  9  operand, two's complement.
REQ-007 SHALL have port in_sub  input  1  0 = add operand, 1 = subtract operand.
REQ-008 SHALL have port flush  input  1  abort current accumulation.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  9  accumulated result, two's complement.
REQ-012 SHALL have port out_carry  output  1  carry-out of the last operation.
REQ-013 SHALL have port out_ovf  output  1  sticky signed overflow over the run.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, OUT.
REQ-015 SHALL, per accepted beat (in_valid & in_ready), compute acc + (in_sub ? ~in_data : in_data) + in_sub in 10 bits; bits[8:0] become new acc, bit 9 becomes carry.
REQ-016 SHALL set ovf sticky when the 9-bit signed result of a beat differs from the true signed result (operand signs equal after inversion, result sign differs).
REQ-017 SHALL, in IDLE, hold acc=0, cnt=0, ovf=0, in_ready=1; an accepted beat updates acc, cnt=1, goes to ACCUM (or OUT if COUNT==1).
REQ-018 SHALL, in ACCUM, keep in_ready=1, update on each accepted beat, increment cnt; on the beat making cnt==COUNT go to OUT.
REQ-019 SHALL assert out_valid the cycle after the COUNT-th accepted beat (latency 1 cycle).
REQ-020 SHALL, in OUT, drive in_ready=0, out_valid=1, hold out_data/out_carry/out_ovf stable until out_ready=1.
REQ-021 SHALL, on out_valid & out_ready, return to IDLE next cycle with acc, cnt, ovf cleared; no operand accepted that cycle.
REQ-022 SHALL, on flush in IDLE or ACCUM, go to IDLE clearing acc, cnt, ovf; flush overrides a simultaneous in_valid beat.
REQ-023 SHALL ignore flush in OUT.
REQ-024 SHALL ignore in_valid/in_sub/in_data whenever in_ready=0.
REQ-025 SHALL drive out_data, out_carry, out_ovf to 0 whenever out_valid=0.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter IDLE with acc=0, cnt=0, carry=0, ovf=0, out_valid=0, in_ready=1 next cycle, from any state including OUT.
REQ-027 SHALL give rst priority over flush, in_valid and out_ready.

Configuration
REQ-028 SHALL, when macro ADDSUB9_ACC_SAT_EN is defined, clamp an overflowing beat result to 0x0FF (positive overflow) or 0x100 (negative overflow) and still set ovf.
REQ-029 SHALL, when ADDSUB9_ACC_SAT_EN is undefined, wrap results modulo 512; ovf behaviour unchanged.
REQ-030 SHALL compute out_carry identically in both builds (raw bit 9 before clamping).

Verification
REQ-031 SHALL cover: COUNT=4, add 10,20,30,40 -> out_data=0x064, out_carry=0, out_ovf=0, out_valid one cycle after 4th beat.
REQ-032 SHALL cover: add 100, sub 5, add 1, sub 1 -> out_data=0x05F, out_carry=1, out_ovf=0.
REQ-033 SHALL cover: add 200, add 100, add 0, add 0 -> out_ovf=1; out_data=0x12C without macro, 0x0FF with ADDSUB9_ACC_SAT_EN.
REQ-034 SHALL cover: result ready, out_ready low 5 cycles with in_valid high -> out_valid held, out_data stable, in_ready=0, no beat consumed; out_ready high -> IDLE next cycle.
REQ-035 SHALL cover: 2 beats (add 7, add 7), flush with in_valid high, then add 1,2,3,4 -> out_data=0x00A.
REQ-036 SHALL cover: rst asserted during OUT -> out_valid=0, in_ready=1 next cycle; subsequent add 1 x4 -> out_data=0x004.
